// File: rtl/zigbee_pkg.sv
// ============================================================================
// Module      : zigbee_pkg
// Description : Shared types, frame headers and instruction codes for the
//               Zigbee request/reply link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package zigbee_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } link_state_t;

    typedef enum logic [1:0] {
        RX_HUNT  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [4:0] REQ_HDR   = 5'b01010;
    localparam logic [4:0] REPLY_HDR = 5'b10101;

    // Instruction codes shared with the main controller; 3'b000 has no name
    localparam logic [2:0] INSTR_FORWARD       = 3'b001;
    localparam logic [2:0] INSTR_RIGHT         = 3'b010;
    localparam logic [2:0] INSTR_LEFT          = 3'b011;
    localparam logic [2:0] INSTR_TURN180       = 3'b100;
    localparam logic [2:0] INSTR_BACKWARD      = 3'b101;
    localparam logic [2:0] INSTR_FORWARD_SHORT = 3'b110;
    localparam logic [2:0] INSTR_VISIT_STATION = 3'b111;

    // Full 8N1 line frame, transmitted from bit 0 upward
    function automatic logic [9:0] make_frame(input logic [2:0] status);
        return {1'b1, REQ_HDR, status, 1'b0};
    endfunction

    function automatic logic reply_valid(input logic [7:0] rx_byte);
        return rx_byte[7:3] == REPLY_HDR;
    endfunction

endpackage

`default_nettype wire

// File: rtl/zigbee_link_if.sv
// ============================================================================
// Module      : zigbee_link_if
// Description : Controller handshake and Zigbee UART lines of the link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface zigbee_link_if;
    logic       start_communication;
    logic [2:0] status;
    logic       uart_rx;
    logic       uart_tx;
    logic [2:0] c_out;
    logic       received_instruction;
    logic       busy;

    modport master (
        output start_communication,
        output status,
        output uart_rx,
        input  uart_tx,
        input  c_out,
        input  received_instruction,
        input  busy
    );

    modport slave (
        input  start_communication,
        input  status,
        input  uart_rx,
        output uart_tx,
        output c_out,
        output received_instruction,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/zigbee_link_uart_rx.sv
// ============================================================================
// Module      : zigbee_link_uart_rx
// Description : 8N1 UART receiver with synchroniser, mid-bit sampling and
//               framing check; drops any byte in progress when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zigbee_link_uart_rx
    import zigbee_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o
);

    localparam int unsigned   CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             meta_q;
    logic             sync_q;
    logic             prev_q;
    rx_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             w_fall;

    assign w_fall  = prev_q & ~sync_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RX_HUNT;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!enable_i) begin
                state_q <= RX_HUNT;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    RX_HUNT: begin
                        cnt_q <= '0;
                        if (w_fall) state_q <= RX_START;
                    end
                    RX_START: begin
                        // A start bit that is high again at mid-bit was a glitch
                        if (cnt_q == HALF_LAST) begin
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            state_q <= sync_q ? RX_HUNT : RX_DATA;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    RX_DATA: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q   <= '0;
                            shift_q <= {sync_q, shift_q[7:1]};
                            if (bit_q == 3'd7) state_q <= RX_STOP;
                            else               bit_q   <= bit_q + 3'd1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    RX_STOP: begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= RX_HUNT;
                            if (sync_q) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= RX_HUNT;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/zigbee_link.sv
// ============================================================================
// Module      : zigbee_link
// Description : One status-request / instruction-reply exchange over the
//               Zigbee UART per start_communication. ZIGBEE_TIMEOUT_EN adds
//               reply timeout with automatic resend.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zigbee_link
    import zigbee_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned BAUD           = 9600,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic          clk,
    input  logic          reset,
    zigbee_link_if.slave  bus
);

    localparam int unsigned      CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned      CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);

    link_state_t      state_q;
    logic [2:0]       status_q;
    logic [9:0]       tx_shift_q;
    logic [3:0]       tx_bit_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       c_out_q;
    logic             rx_ins_q;
    logic             busy_q;

    logic [7:0]       w_rx_data;
    logic             w_rx_valid;
    logic             w_reply_ok;
    logic             w_timeout;

    zigbee_link_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .enable_i (state_q == WAIT),
        .rx_i     (bus.uart_rx),
        .data_o   (w_rx_data),
        .valid_o  (w_rx_valid)
    );

    assign w_reply_ok = w_rx_valid && reply_valid(w_rx_data);

`ifdef ZIGBEE_TIMEOUT_EN
    localparam int unsigned     TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;

    assign w_timeout = (state_q == WAIT) && (to_cnt_q == TO_LAST);

    // Held at zero outside WAIT so every wait period starts fresh
    always_ff @(posedge clk) begin
        if (reset || (state_q != WAIT)) begin
            to_cnt_q <= '0;
        end else if (!w_timeout) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    // Without the timeout the parameter only keeps the instance interface uniform
    assign w_timeout = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

    // The line is driven straight from bit 0 of the frame shifter; all ones = idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            status_q   <= '0;
            tx_shift_q <= '1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
            c_out_q    <= '0;
            rx_ins_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_communication) begin
                        state_q    <= SEND;
                        status_q   <= bus.status;
                        tx_shift_q <= make_frame(bus.status);
                        tx_bit_q   <= '0;
                        tx_cnt_q   <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                SEND: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                        if (tx_bit_q == 4'd9) state_q  <= WAIT;
                        else                  tx_bit_q <= tx_bit_q + 4'd1;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                WAIT: begin
                    // A reply landing on the timeout cycle still completes the exchange
                    if (w_reply_ok) begin
                        c_out_q  <= w_rx_data[2:0];
                        rx_ins_q <= 1'b1;
                        state_q  <= DONE;
                    end else if (w_timeout) begin
                        state_q    <= SEND;
                        tx_shift_q <= make_frame(status_q);
                        tx_bit_q   <= '0;
                        tx_cnt_q   <= '0;
                    end
                end
                DONE: begin
                    rx_ins_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.uart_tx              = tx_shift_q[0];
    assign bus.c_out                = c_out_q;
    assign bus.received_instruction = rx_ins_q;
    assign bus.busy                 = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_zigbee_link.sv
// ============================================================================
// Module      : tb_zigbee_link
// Description : Self-checking bench for zigbee_link; decodes the request line,
//               plays the PC side and compares against a byte-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_zigbee_link;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned TIMEOUT  = 2000;
    localparam int          CPB      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic reset = 1'b1;
    zigbee_link_if bus();

    zigbee_link #(
        .CLK_FREQ       (CLK_FREQ),
        .BAUD           (BAUD),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] tx_q[$];
    int         tx_t[$];
    int         pulses = 0;
    int         long_pulses = 0;
    logic [2:0] pulse_c[$];
    logic       pulse_busy[$];
    logic       busy_after[$];
    logic [2:0] exp_cout = 3'b000;

    // Byte-level model of the protocol
    function automatic logic [7:0] req_of(input logic [2:0] s);
        return 8'(80 + int'(s));
    endfunction
    function automatic bit reply_ok(input logic [7:0] b);
        return (int'(b) / 8) == 21;
    endfunction
    function automatic logic [7:0] reply_of(input logic [2:0] ins);
        return 8'(21 * 8 + int'(ins));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Request-line decoder
    initial begin
        logic [7:0] b;
        int t0;
        forever begin
            @(negedge bus.uart_tx);
            t0 = cyc;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = bus.uart_tx;
            end
            repeat (CPB) @(negedge clk);
            tx_q.push_back(b);
            tx_t.push_back(t0);
        end
    end

    // Instruction-pulse observer
    initial begin
        logic ri_prev;
        ri_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ri_prev) busy_after.push_back(bus.busy);
                if (bus.received_instruction) begin
                    pulses++;
                    pulse_c.push_back(bus.c_out);
                    pulse_busy.push_back(bus.busy);
                    if (ri_prev) long_pulses++;
                end
            end
            ri_prev = bus.received_instruction;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.uart_rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = b[i];
            repeat (CPB) tick();
        end
        bus.uart_rx = stop_bit;
        repeat (CPB) tick();
        bus.uart_rx = 1'b1;
        repeat (4) tick();
    endtask

    task automatic begin_txn(input logic [2:0] st);
        bus.status = st;
        bus.start_communication = 1'b1;
        tick();
        bus.start_communication = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (tx_q.size() >= n) ok = 1'b1;
            else tick();
        end
        if (tx_q.size() >= n) ok = 1'b1;
    endtask

    task automatic wait_pulse(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (pulses >= n) ok = 1'b1;
            else tick();
        end
        if (pulses >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (bus.uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", bus.uart_tx); end
        checks++; if (bus.c_out !== 3'b000) begin errors++; $display("FAIL reset_cout: got %b want 000", bus.c_out); end
        checks++; if (bus.received_instruction !== 1'b0) begin errors++; $display("FAIL reset_ri: got %b want 0", bus.received_instruction); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_basic();
        int n0, p0;
        bit ok;
        logic [7:0] got;
        n0 = tx_q.size(); p0 = pulses;
        begin_txn(3'b101);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise: got %b want 1", bus.busy); end
        wait_tx(n0 + 1, 200, ok);
        got = ok ? tx_q[n0] : 8'hxx;
        checks++; if (got !== req_of(3'b101)) begin errors++; $display("FAIL basic_request: got %h want %h", got, req_of(3'b101)); end
        repeat (10) tick();
        send_byte(8'hA9, 1'b1);
        if (reply_ok(8'hA9)) exp_cout = 3'(8'hA9 % 8);
        wait_pulse(p0 + 1, 80, ok);
        repeat (3) tick();
        checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL basic_pulse_count: got %0d want %0d", pulses - p0, 1); end
        got = (pulse_c.size() > p0) ? {5'b0, pulse_c[p0]} : 8'hxx;
        checks++; if (got[2:0] !== exp_cout || exp_cout !== 3'b001) begin errors++; $display("FAIL basic_cout: got %b want 001", got[2:0]); end
        got[0] = (pulse_busy.size() > p0) ? pulse_busy[p0] : 1'bx;
        checks++; if (got[0] !== 1'b1) begin errors++; $display("FAIL basic_busy_in_done: got %b want 1", got[0]); end
        got[0] = (busy_after.size() > p0) ? busy_after[p0] : 1'bx;
        checks++; if (got[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b want 0", got[0]); end
        checks++; if (long_pulses !== 0) begin errors++; $display("FAIL basic_pulse_width: got %0d long pulses want 0", long_pulses); end
        repeat (5) tick();
    endtask

    task automatic test_bad_then_good(input logic [7:0] bad, input logic bad_stop, input logic [7:0] good);
        int n0, p0;
        bit ok;
        logic [7:0] got;
        logic [2:0] st;
        n0 = tx_q.size(); p0 = pulses;
        st = 3'($urandom_range(0, 7));
        begin_txn(st);
        wait_tx(n0 + 1, 200, ok);
        got = ok ? tx_q[n0] : 8'hxx;
        checks++; if (got !== req_of(st)) begin errors++; $display("FAIL bad_request: got %h want %h", got, req_of(st)); end
        repeat (10) tick();
        send_byte(bad, bad_stop);
        repeat (20) tick();
        checks++; if (pulses !== p0) begin errors++; $display("FAIL bad_discard(%h stop=%b): got %0d pulses want 0", bad, bad_stop, pulses - p0); end
        send_byte(good, 1'b1);
        exp_cout = 3'(int'(good) % 8);
        wait_pulse(p0 + 1, 80, ok);
        repeat (5) tick();
        checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL bad_good_pulses: got %0d want 1", pulses - p0); end
        got = (pulse_c.size() > p0) ? {5'b0, pulse_c[p0]} : 8'hxx;
        checks++; if (got[2:0] !== exp_cout) begin errors++; $display("FAIL bad_good_cout: got %b want %b", got[2:0], exp_cout); end
        checks++; if (bus.c_out !== exp_cout) begin errors++; $display("FAIL bad_good_hold: got %b want %b", bus.c_out, exp_cout); end
        repeat (5) tick();
    endtask

    task automatic test_timeout();
        int n0, p0;
        bit ok;
        logic [7:0] got;
        n0 = tx_q.size(); p0 = pulses;
        begin_txn(3'b011);
        bus.status = 3'b110;
        wait_tx(n0 + 1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL timeout_first_req: got none want %h", req_of(3'b011)); end
`ifdef ZIGBEE_TIMEOUT_EN
        wait_tx(n0 + 2, TIMEOUT + 300, ok);
        got = ok ? tx_q[n0 + 1] : 8'hxx;
        checks++; if (got !== req_of(3'b011)) begin errors++; $display("FAIL timeout_resend_byte: got %h want %h", got, req_of(3'b011)); end
        checks++; if (ok && (tx_t[n0 + 1] - tx_t[n0]) !== 10 * CPB + int'(TIMEOUT)) begin errors++; $display("FAIL timeout_resend_gap: got %0d want %0d", tx_t[n0 + 1] - tx_t[n0], 10 * CPB + int'(TIMEOUT)); end
        repeat (10) tick();
`else
        repeat (10000) tick();
        checks++; if (tx_q.size() !== n0 + 1) begin errors++; $display("FAIL no_resend: got %0d requests want 1", tx_q.size() - n0); end
`endif
        send_byte(reply_of(3'b110), 1'b1);
        exp_cout = 3'b110;
        wait_pulse(p0 + 1, 80, ok);
        got = (pulse_c.size() > p0) ? {5'b0, pulse_c[p0]} : 8'hxx;
        checks++; if (got[2:0] !== exp_cout) begin errors++; $display("FAIL timeout_reply_cout: got %b want %b", got[2:0], exp_cout); end
        repeat (10) tick();
    endtask

    task automatic test_start_pulse();
        int n0, p0;
        bit ok;
        logic [7:0] got;
        n0 = tx_q.size(); p0 = pulses;
        begin_txn(3'b010);
        wait_tx(n0 + 1, 200, ok);
        repeat (10) tick();
        for (int i = 0; i < 5; i++) begin
            bus.start_communication = 1'b1; tick();
            bus.start_communication = 1'b0; tick();
        end
        send_byte(8'hAC, 1'b1);
        exp_cout = 3'b100;
        wait_pulse(p0 + 1, 80, ok);
        got = (pulse_c.size() > p0) ? {5'b0, pulse_c[p0]} : 8'hxx;
        checks++; if (got[2:0] !== exp_cout) begin errors++; $display("FAIL start_pulse_cout: got %b want %b", got[2:0], exp_cout); end
        repeat (200) tick();
        checks++; if (tx_q.size() !== n0 + 1) begin errors++; $display("FAIL start_toggle_extra_req: got %0d requests want 1", tx_q.size() - n0); end
        checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL start_pulse_count: got %0d want 1", pulses - p0); end
    endtask

    task automatic test_idle_reply();
        int n0, p0;
        n0 = tx_q.size(); p0 = pulses;
        send_byte(reply_of(3'b011), 1'b1);
        repeat (20) tick();
        checks++; if (pulses !== p0) begin errors++; $display("FAIL idle_reply_pulse: got %0d want 0", pulses - p0); end
        checks++; if (bus.c_out !== exp_cout) begin errors++; $display("FAIL idle_reply_cout: got %b want %b", bus.c_out, exp_cout); end
        checks++; if (tx_q.size() !== n0 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_reply_activity: got req=%0d busy=%b want 0/0", tx_q.size() - n0, bus.busy); end
    endtask

    task automatic test_random();
        logic [7:0] bad;
        for (int k = 0; k < 5; k++) begin
            bad = 8'($urandom_range(0, 255));
            if (reply_ok(bad)) bad = bad ^ 8'h80;
            test_bad_then_good(bad, 1'($urandom_range(0, 1)), reply_of(3'($urandom_range(0, 7))));
        end
    endtask

    task automatic test_reset_mid_send();
        int p0;
        bit ok;
        logic [7:0] got;
        logic [2:0] st;
        begin_txn(3'b111);
        repeat (30) tick();
        reset = 1'b1;
        tick();
        checks++; if (bus.uart_tx !== 1'b1) begin errors++; $display("FAIL rst_send_tx: got %b want 1", bus.uart_tx); end
        checks++; if (bus.busy !== 1'b0 || bus.c_out !== 3'b000) begin errors++; $display("FAIL rst_send_state: got busy=%b c_out=%b want 0/000", bus.busy, bus.c_out); end
        reset = 1'b0;
        exp_cout = 3'b000;
        repeat (150) tick();
        tx_q.delete(); tx_t.delete();
        repeat (200) tick();
        checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL rst_send_idle: got %0d requests want 0", tx_q.size()); end
        p0 = pulses;
        st = 3'($urandom_range(0, 7));
        begin_txn(st);
        wait_tx(1, 200, ok);
        got = ok ? tx_q[0] : 8'hxx;
        checks++; if (got !== req_of(st)) begin errors++; $display("FAIL rst_restart_req: got %h want %h", got, req_of(st)); end
        repeat (10) tick();
        send_byte(reply_of(3'b000), 1'b1);
        wait_pulse(p0 + 1, 80, ok);
        checks++; if (!ok || bus.c_out !== 3'b000) begin errors++; $display("FAIL rst_zero_instr: got pulse=%b c_out=%b want 1/000", ok, bus.c_out); end
    endtask

    initial begin
        bus.start_communication = 1'b0;
        bus.status = 3'b000;
        bus.uart_rx = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_bad_then_good(8'h3A, 1'b1, 8'hAF);
        test_bad_then_good(8'hAA, 1'b0, 8'hAA);
        test_timeout();
        test_start_pulse();
        test_idle_reply();
        test_random();
        test_reset_mid_send();
        checks++; if (long_pulses !== 0) begin errors++; $display("FAIL pulse_width_total: got %0d long pulses want 0", long_pulses); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
